// File: rtl/ex_mul_unit.sv
// Iterative shift-add multiplier for the EX stage, returning the low XLEN bits of EX_a*EX_b.
// Latency: XLEN+1 cycles of MUL_stall for nonzero operands, 1 cycle when either operand is zero.
// Backpressure: MUL_stall freezes fetch/decode/EX while working; MEM_stall holds the result in DONE.
module ex_mul_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            EX_mul,
    input  logic [XLEN-1:0] EX_a,
    input  logic [XLEN-1:0] EX_b,
    input  logic [4:0]      EX_rd,
    input  logic            EX_we,
    input  logic            MEM_stall,
    output logic            MUL_stall,
    output logic            MUL_valid,
    output logic [XLEN-1:0] MUL_result,
    output logic [4:0]      MUL_rd,
    output logic            MUL_we
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] acc;
    logic [CW-1:0]   cnt;
    logic [4:0]      rd_q;
    logic            we_q;
    logic            zero_op;

    assign zero_op = (EX_a == '0) || (EX_b == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // DONE exits to IDLE only; a multiply waiting in EX is taken on the following edge.
    always_comb begin
        state_nxt = state;
        MUL_stall = 1'b0;
        MUL_valid = 1'b0;
        case (state)
            IDLE: begin
                MUL_stall = EX_mul;
                if (EX_mul) begin
                    state_nxt = zero_op ? DONE : BUSY;
                end
            end
            BUSY: begin
                MUL_stall = 1'b1;
                if (cnt == LAST_ITER) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                MUL_valid = 1'b1;
                if (!MEM_stall) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            rd_q   <= '0;
            we_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (EX_mul) begin
                        rd_q <= EX_rd;
                        we_q <= EX_we;
                        acc  <= '0;
                        cnt  <= '0;
                        if (!zero_op) begin
                            mcand  <= EX_a;
                            mplier <= EX_b;
                        end
                    end
                end
                BUSY: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign MUL_result = MUL_valid ? acc  : '0;
    assign MUL_rd     = MUL_valid ? rd_q : '0;
    assign MUL_we     = MUL_valid & we_q;

endmodule

// File: tb/tb_ex_mul_unit.sv
// Drives ex_mul_unit through a behavioural D-to-EX slot that advances whenever MUL_stall is low,
// and scores every retirement against full-width products truncated to 32 bits.
module tb_ex_mul_unit;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
        int          hold;
        int          gap;
        logic [31:0] res;
        int          lat;
    } op_t;

    logic        clk;
    logic        rst_n;
    logic        EX_mul;
    logic [31:0] EX_a;
    logic [31:0] EX_b;
    logic [4:0]  EX_rd;
    logic        EX_we;
    logic        MEM_stall;
    logic        MUL_stall;
    logic        MUL_valid;
    logic [31:0] MUL_result;
    logic [4:0]  MUL_rd;
    logic        MUL_we;

    int  n_cmp = 0;
    int  n_mis = 0;
    op_t issue_q[$];
    op_t exp_q[$];
    bit  ex_full   = 0;
    int  ex_cnt    = 0;
    bit  prev_v    = 0;
    int  held      = 0;
    bit  hold_pend = 0;
    bit  drop_pend = 0;

    ex_mul_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .EX_mul    (EX_mul),
        .EX_a      (EX_a),
        .EX_b      (EX_b),
        .EX_rd     (EX_rd),
        .EX_we     (EX_we),
        .MEM_stall (MEM_stall),
        .MUL_stall (MUL_stall),
        .MUL_valid (MUL_valid),
        .MUL_result(MUL_result),
        .MUL_rd    (MUL_rd),
        .MUL_we    (MUL_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                               input logic we, input int hold, input int gap);
        op_t o;
        logic [63:0] full;
        full   = 64'(a) * 64'(b);
        o.a    = a;
        o.b    = b;
        o.rd   = rd;
        o.we   = we;
        o.hold = hold;
        o.gap  = gap;
        o.res  = full[31:0];
        o.lat  = (a == 0 || b == 0) ? 1 : 33;
        return o;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic step();
        logic        s, v, w, adv, mem;
        logic [31:0] r;
        logic [4:0]  d;
        op_t         nx;
        @(negedge clk);
        s = MUL_stall;
        v = MUL_valid;
        r = MUL_result;
        d = MUL_rd;
        w = MUL_we;
        if (ex_full && s) ex_cnt++;
        if (!ex_full) check("stall_empty_ex", 64'(s), 64'd0);
        if (drop_pend) begin
            check("valid_drop", 64'(v), 64'd0);
            drop_pend = 0;
        end
        if (hold_pend) begin
            check("valid_held", 64'(v), 64'd1);
            hold_pend = 0;
        end
        mem = 1'($urandom_range(0, 1));
        if (v) begin
            check("stall_in_done", 64'(s), 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 64'(v), 64'd0);
            end else begin
                if (!prev_v && ex_full) check("latency", 64'(ex_cnt), 64'(exp_q[0].lat));
                check("result", 64'(r), 64'(exp_q[0].res));
                check("rd", 64'(d), 64'(exp_q[0].rd));
                check("we", 64'(w), 64'(exp_q[0].we));
                held++;
                mem = (held <= exp_q[0].hold);
                if (mem) begin
                    hold_pend = 1;
                end else begin
                    void'(exp_q.pop_front());
                    held      = 0;
                    drop_pend = 1;
                end
            end
        end else begin
            check("idle_outputs", 64'({r, d, w}), 64'd0);
        end
        MEM_stall = mem;
        prev_v    = v;
        adv       = !s && (!ex_full || ex_cnt > 0);
        @(posedge clk);
        #1;
        if (adv) begin
            ex_cnt = 0;
            if (issue_q.size() > 0 && issue_q[0].gap == 0) begin
                nx      = issue_q.pop_front();
                EX_mul  = 1'b1;
                EX_a    = nx.a;
                EX_b    = nx.b;
                EX_rd   = nx.rd;
                EX_we   = nx.we;
                ex_full = 1;
                exp_q.push_back(nx);
            end else begin
                if (issue_q.size() > 0) issue_q[0].gap = issue_q[0].gap - 1;
                EX_mul  = 1'b0;
                EX_a    = 32'($urandom);
                EX_b    = 32'($urandom);
                ex_full = 0;
            end
        end else if (ex_full && s && ex_cnt > 0) begin
            // operands already captured: later EX changes must not disturb the result
            EX_a  = 32'($urandom);
            EX_b  = 32'($urandom);
            EX_rd = 5'($urandom);
            EX_we = 1'($urandom);
        end
    endtask

    task automatic run_drain(input int max_cycles);
        int n = 0;
        while ((issue_q.size() > 0 || exp_q.size() > 0) && n < max_cycles) begin
            step();
            n++;
        end
        check("drain", 64'(issue_q.size() + exp_q.size()), 64'd0);
        repeat (2) step();
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        EX_mul    = 1'b0;
        EX_a      = '0;
        EX_b      = '0;
        EX_rd     = '0;
        EX_we     = 1'b0;
        MEM_stall = 1'b0;
        #3;
        check("rst_stall", 64'(MUL_stall), 64'd0);
        check("rst_valid", 64'(MUL_valid), 64'd0);
        check("rst_outputs", 64'({MUL_result, MUL_rd, MUL_we}), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();

        issue_q.push_back(mk(32'd3, 32'd5, 5'd7, 1'b1, 0, 0));
        issue_q.push_back(mk(32'h0001_0000, 32'h0001_0000, 5'd1, 1'b1, 0, 1));
        issue_q.push_back(mk(32'hFFFF_FFFF, 32'd2, 5'd2, 1'b0, 0, 1));
        issue_q.push_back(mk(32'd0, 32'd9, 5'd3, 1'b1, 0, 1));
        issue_q.push_back(mk(32'd11, 32'd13, 5'd4, 1'b1, 4, 1));
        issue_q.push_back(mk(32'd6, 32'd7, 5'd5, 1'b1, 0, 2));
        issue_q.push_back(mk(32'd2, 32'd9, 5'd6, 1'b1, 0, 0));
        issue_q.push_back(mk(32'h8000_0001, 32'd0, 5'd31, 1'b0, 2, 0));
        run_drain(1000);

        for (int i = 0; i < 40; i++) begin
            issue_q.push_back(mk(rnd_operand(), rnd_operand(), 5'($urandom), 1'($urandom),
                                 int'($urandom_range(0, 3)), int'($urandom_range(0, 2))));
        end
        run_drain(5000);

        // abort a multiply after its tenth BUSY iteration
        issue_q.push_back(mk(32'd1234, 32'd5678, 5'd9, 1'b1, 0, 0));
        n = 0;
        while (ex_cnt < 11 && n < 200) begin
            step();
            n++;
        end
        check("rst_reach_iter10", 64'(ex_cnt), 64'd11);
        rst_n  = 1'b0;
        EX_mul = 1'b0;
        #1;
        check("abort_stall", 64'(MUL_stall), 64'd0);
        check("abort_valid", 64'(MUL_valid), 64'd0);
        check("abort_outputs", 64'({MUL_result, MUL_rd, MUL_we}), 64'd0);
        exp_q.delete();
        issue_q.delete();
        ex_full   = 0;
        ex_cnt    = 0;
        prev_v    = 0;
        held      = 0;
        hold_pend = 0;
        drop_pend = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) step();

        issue_q.push_back(mk(32'd3, 32'd5, 5'd7, 1'b1, 1, 0));
        run_drain(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/ex_mul_unit.md
EX_MUL_UNIT -- requirements
Module: ex_mul_unit

Interface
REQ-001 Parameter XLEN, 32, operand and result width.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 EX_mul  input  1  a multiply instruction is present in EX; held stable by the D-to-EX register while MUL_stall=1.
REQ-005 EX_a  input  XLEN  multiplicand.
REQ-006 EX_b  input  XLEN  multiplier.
REQ-007 EX_rd  input  5  destination register of the multiply.
REQ-008 EX_we  input  1  register write enable of the multiply.
REQ-009 MEM_stall  input  1  downstream hold; the result must not retire while high.
REQ-010 MUL_stall  output  1  freeze request to the fetch/decode stages and the D-to-EX register.
REQ-011 MUL_valid  output  1  MUL_result/MUL_rd/MUL_we are valid this cycle.
REQ-012 MUL_result  output  XLEN  low XLEN bits of EX_a*EX_b.
REQ-013 MUL_rd  output  5  captured EX_rd.
REQ-014 MUL_we  output  1  captured EX_we, qualified by MUL_valid.

Function
REQ-015 FSM SHALL have exactly three states: IDLE, BUSY, DONE.
REQ-016 IDLE, EX_mul=1, both operands nonzero: at posedge capture EX_a into multiplicand register, EX_b into multiplier register, clear accumulator, capture EX_rd/EX_we, clear iteration counter, go to BUSY.
REQ-017 IDLE, EX_mul=1, EX_a==0 or EX_b==0: at posedge capture EX_rd/EX_we, load accumulator with 0, go directly to DONE (zero shortcut).
REQ-018 IDLE, EX_mul=0: remain in IDLE; no register changes.
REQ-019 BUSY: each posedge, if multiplier LSB=1 add multiplicand into accumulator (mod 2^XLEN), shift multiplicand left 1, shift multiplier right 1, increment counter.
REQ-020 BUSY SHALL perform exactly XLEN iterations; the posedge completing iteration XLEN moves to DONE; counter width is clog2(XLEN)+1 bits.
REQ-021 Arithmetic is unsigned shift-add truncated to XLEN bits; the low XLEN bits are identical for signed operands; carries beyond bit XLEN-1 are discarded.
REQ-022 DONE: MUL_valid=1, MUL_result=accumulator, MUL_rd/MUL_we=captured values; at posedge go to IDLE if MEM_stall=0, else stay in DONE with outputs unchanged.
REQ-023 MUL_stall SHALL be combinational: 1 when (IDLE and EX_mul=1) or BUSY; 0 in DONE and in IDLE with EX_mul=0.
REQ-024 Latency: EX_mul sampled in IDLE at posedge k gives MUL_valid high in the cycle after posedge k+XLEN (nonzero operands) or after posedge k (zero shortcut).
REQ-025 DONE-to-IDLE transition SHALL NOT restart a multiply on the same edge; a new multiply is accepted only when sampled in IDLE.
REQ-026 Back-to-back multiplies: second multiply (now in EX) is accepted at the first posedge in IDLE after DONE exits; no result is lost or duplicated.
REQ-027 EX_a/EX_b/EX_rd/EX_we changes during BUSY or DONE SHALL have no effect on the in-flight result.
REQ-028 MUL_valid=0 forces MUL_we=0 and MUL_result=0, MUL_rd=0.

Reset
REQ-029 rst_n=0 SHALL immediately (asynchronously) force state IDLE, counter 0, accumulator/operand/rd/we registers 0.
REQ-030 During and after reset until a multiply is accepted: MUL_stall=0 (given EX_mul=0), MUL_valid=0, MUL_result=0, MUL_rd=0, MUL_we=0.
REQ-031 Reset asserted mid-BUSY or in DONE SHALL abort the operation; no MUL_valid pulse follows deassertion.

Verification
REQ-032 EX_a=3, EX_b=5, EX_rd=7, EX_we=1, MEM_stall=0 -> MUL_stall high 33 cycles, then MUL_valid=1 one cycle with MUL_result=15, MUL_rd=7, MUL_we=1.
REQ-033 EX_a=0x0001_0000, EX_b=0x0001_0000 -> MUL_result=0 (overflow truncated), latency 32 BUSY cycles; EX_a=0xFFFF_FFFF, EX_b=2 -> MUL_result=0xFFFF_FFFE.
REQ-034 EX_a=0, EX_b=9 -> MUL_stall high 1 cycle, MUL_valid next cycle, MUL_result=0.
REQ-035 MEM_stall=1 for 4 cycles while in DONE -> MUL_valid and outputs held 5 cycles total, MUL_stall=0 throughout, single retirement.
REQ-036 Two consecutive multiplies (6*7 then 2*9) -> two MUL_valid pulses, results 42 then 18, no restart of the first during its DONE cycle.
REQ-037 rst_n low at BUSY iteration 10 -> outputs 0 immediately, state IDLE, no MUL_valid after release with EX_mul=0.
